// File: rtl/tl_start_debouncer.sv
// Start push-button conditioner: 2-flop synchroniser, debounce FSM, press/release pulses, long-press flag.
// Latency DB_CYCLES+2 edges from btn_in to btn_level/btn_rise (same for release); no backpressure, outputs free-running.
module tl_start_debouncer #(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 200_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_long
);

  localparam int DB_W   = ($clog2(DB_CYCLES) < 1) ? 1 : $clog2(DB_CYCLES);
  localparam int LONG_W = ($clog2(LONG_CYCLES) < 1) ? 1 : $clog2(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_HI  = 2'd1,
    PRESSED = 2'd2,
    ARM_LO  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic                sync_meta, s_sync;
  logic [DB_W-1:0]     db_cnt, db_cnt_nxt;
  logic [LONG_W-1:0]   long_cnt, long_cnt_nxt;
  logic                level_nxt, rise_nxt, fall_nxt, long_nxt;

  // btn_in is asynchronous; only s_sync may feed the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      s_sync    <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      s_sync    <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      db_cnt    <= '0;
      long_cnt  <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
      btn_long  <= 1'b0;
    end else begin
      state     <= state_nxt;
      db_cnt    <= db_cnt_nxt;
      long_cnt  <= long_cnt_nxt;
      btn_level <= level_nxt;
      btn_rise  <= rise_nxt;
      btn_fall  <= fall_nxt;
      btn_long  <= long_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    db_cnt_nxt   = db_cnt;
    long_cnt_nxt = long_cnt;
    level_nxt    = btn_level;
    rise_nxt     = 1'b0;
    fall_nxt     = 1'b0;
    long_nxt     = btn_long;

    case (state)
      IDLE: begin
        if (s_sync) begin
          state_nxt  = ARM_HI;
          db_cnt_nxt = DB_W'(1);
        end
      end

      ARM_HI: begin
        if (!s_sync) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt    = PRESSED;
          db_cnt_nxt   = '0;
          level_nxt    = 1'b1;
          rise_nxt     = 1'b1;
          long_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end

      PRESSED: begin
        // long_cnt saturates; the flag is raised on the edge that sees the last count
        if (long_cnt == LONG_LAST) begin
          long_nxt = 1'b1;
        end else begin
          long_cnt_nxt = long_cnt + LONG_W'(1);
        end
        if (!s_sync) begin
          state_nxt  = ARM_LO;
          db_cnt_nxt = DB_W'(1);
        end
      end

      ARM_LO: begin
        // a release bounce returns to PRESSED with the hold time intact
        if (s_sync) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt    = IDLE;
          db_cnt_nxt   = '0;
          level_nxt    = 1'b0;
          fall_nxt     = 1'b1;
          long_nxt     = 1'b0;
          long_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  a_pulse_excl: assert property (@(posedge clk) disable iff (reset) !(btn_rise && btn_fall));

endmodule

// File: tb/tb_tl_start_debouncer.sv
// Scoreboard bench for tl_start_debouncer: stimulus queues expected output events, a monitor pops and compares them.
module tb_tl_start_debouncer;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int LAT  = DB + 2;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_LON  = 2;
  localparam int EV_LOFF = 3;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic btn_level, btn_rise, btn_fall, btn_long;

  int cyc      = 0;
  int n_checks = 0;
  int n_fails  = 0;
  int exp_kind[$];
  int exp_cyc[$];
  logic lvl_prev  = 1'b0;
  logic long_prev = 1'b0;

  tl_start_debouncer #(
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_long  (btn_long)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int at);
    exp_kind.push_back(kind);
    exp_cyc.push_back(at);
  endtask

  task automatic pop_ev(input int kind);
    int k, c;
    if (exp_kind.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kind, cyc);
    end else begin
      k = exp_kind.pop_front();
      c = exp_cyc.pop_front();
      chk("event_kind", kind, k);
      chk("event_cycle", cyc, c);
    end
  endtask

  task automatic chk_empty(input string name);
    chk(name, exp_kind.size(), 0);
    exp_kind.delete();
    exp_cyc.delete();
  endtask

  task automatic chk_quiet(input string name);
    chk(name, int'({btn_level, btn_rise, btn_fall, btn_long}), 0);
  endtask

  // press at a negedge, hold for 'hold' cycles, release, then let the block settle
  task automatic press_release(input int hold, input bit exp_long, input string name);
    int c0;
    @(negedge clk);
    btn_in = 1'b1;
    c0 = cyc;
    expect_ev(EV_RISE, c0 + LAT);
    if (exp_long) expect_ev(EV_LON, c0 + LAT + LONG);
    repeat (hold) @(negedge clk);
    btn_in = 1'b0;
    expect_ev(EV_FALL, c0 + hold + LAT);
    if (exp_long) expect_ev(EV_LOFF, c0 + hold + LAT);
    repeat (12) @(negedge clk);
    chk_empty(name);
  endtask

  // monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        chk_quiet("outputs_in_reset");
        lvl_prev  = 1'b0;
        long_prev = 1'b0;
        continue;
      end
      chk("rise_fall_exclusive", int'(btn_rise & btn_fall), 0);
      if (btn_level != lvl_prev)
        chk("level_change_has_pulse", int'(btn_level ? btn_rise : btn_fall), 1);
      if (btn_rise) pop_ev(EV_RISE);
      if (btn_fall) pop_ev(EV_FALL);
      if (btn_long && !long_prev) pop_ev(EV_LON);
      if (!btn_long && long_prev) pop_ev(EV_LOFF);
      lvl_prev  = btn_level;
      long_prev = btn_long;
    end
  end

  // stimulus
  initial begin
    int c0;
    reset  = 1'b1;
    btn_in = 1'b1;

    // reset held with button pressed, then released
    @(negedge clk);
    chk_quiet("reset_hold_0");
    @(negedge clk);
    chk_quiet("reset_hold_1");
    reset = 1'b0;
    expect_ev(EV_RISE, cyc + LAT);
    repeat (10) @(negedge clk);
    btn_in = 1'b0;
    expect_ev(EV_FALL, cyc + LAT);
    repeat (12) @(negedge clk);
    chk_empty("reset_release_events");

    // clean press, released before the long-press threshold
    press_release(15, 1'b0, "clean_press_events");

    // bounce 1,0,1,0 in 2-cycle steps, then stable high
    @(negedge clk);
    btn_in = 1'b1;
    repeat (2) @(negedge clk);
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    btn_in = 1'b1;
    repeat (2) @(negedge clk);
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    btn_in = 1'b1;
    expect_ev(EV_RISE, cyc + LAT);
    repeat (10) @(negedge clk);
    btn_in = 1'b0;
    expect_ev(EV_FALL, cyc + LAT);
    repeat (12) @(negedge clk);
    chk_empty("bounce_events");

    // lone 3-cycle glitch: one sample short of acceptance
    @(negedge clk);
    btn_in = 1'b1;
    repeat (3) @(negedge clk);
    btn_in = 1'b0;
    repeat (12) @(negedge clk);
    chk_empty("glitch_3cyc_events");

    // long press
    press_release(40, 1'b1, "long_press_events");

    // 2-cycle release glitch while pressed delays btn_long by 2
    @(negedge clk);
    btn_in = 1'b1;
    c0 = cyc;
    expect_ev(EV_RISE, c0 + LAT);
    expect_ev(EV_LON, c0 + LAT + LONG + 2);
    repeat (10) @(negedge clk);
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    btn_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("glitch_level_held", int'(btn_level), 1);
    repeat (24) @(negedge clk);
    btn_in = 1'b0;
    expect_ev(EV_FALL, cyc + LAT);
    expect_ev(EV_LOFF, cyc + LAT);
    repeat (12) @(negedge clk);
    chk_empty("release_glitch_events");

    // asynchronous reset while pressed, button still held after release
    @(negedge clk);
    btn_in = 1'b1;
    c0 = cyc;
    expect_ev(EV_RISE, c0 + LAT);
    repeat (10) @(negedge clk);
    chk("pre_reset_level", int'(btn_level), 1);
    chk_empty("pre_reset_events");
    #2 reset = 1'b1;
    #1 chk_quiet("async_reset_outputs");
    #19 reset = 1'b0;
    expect_ev(EV_RISE, cyc + LAT);
    repeat (10) @(negedge clk);
    btn_in = 1'b0;
    expect_ev(EV_FALL, cyc + LAT);
    repeat (12) @(negedge clk);
    chk_empty("post_reset_events");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
